// File: rtl/fb_console_writer.sv
// Byte-stream console writer for the VGA text framebuffer: cursor tracking, control codes, clears.
// Optional FB_CONSOLE_AUTOCLEAR_EN blanks each destination row on a row advance.
module fb_console_writer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 30,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  fb_data,
  output logic [11:0] fb_addr,
  output logic        fb_we,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam int unsigned TOTAL = COLS * ROWS;
  localparam int unsigned CNT_W = 13;

  generate
    if (TOTAL > 4096) begin : g_size_check
      $fatal(1, "fb_console_writer: COLS*ROWS exceeds the 4096-entry framebuffer");
    end
  endgenerate

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1
`ifdef FB_CONSOLE_AUTOCLEAR_EN
    ,
    CLR_LINE = 2'd2
`endif
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   clr_cnt;
  logic [11:0]        row_base;
  logic               row_last;
  logic [4:0]         adv_row;
  logic [11:0]        adv_base;
  logic               printable;

  assign in_ready = (state == IDLE);

  // Row-advance targets; row_base tracks row*COLS without a multiplier
  always_comb begin
    row_last  = (cursor_row == 5'(ROWS - 1));
    adv_row   = row_last ? 5'd0 : cursor_row + 5'd1;
    adv_base  = row_last ? 12'd0 : row_base + 12'(COLS);
    printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CLR_ALL;
      clr_cnt    <= '0;
      row_base   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
    end else begin
      fb_we <= 1'b0;
      case (state)
        CLR_ALL: begin
          if (clr_cnt == CNT_W'(TOTAL)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            fb_we   <= 1'b1;
            fb_addr <= 12'(clr_cnt);
            fb_data <= FILL;
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end

`ifdef FB_CONSOLE_AUTOCLEAR_EN
        CLR_LINE: begin
          if (clr_cnt == CNT_W'(COLS)) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            fb_we   <= 1'b1;
            fb_addr <= row_base + 12'(clr_cnt);
            fb_data <= FILL;
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end
`endif

        IDLE: begin
          if (in_valid) begin
            if (printable) begin
              fb_we   <= 1'b1;
              fb_addr <= row_base + 12'(cursor_col);
              fb_data <= in_data;
              if (cursor_col == 7'(COLS - 1)) begin
                cursor_col <= '0;
                cursor_row <= adv_row;
                row_base   <= adv_base;
`ifdef FB_CONSOLE_AUTOCLEAR_EN
                // Character write occupies this cycle; the row clear follows
                state      <= CLR_LINE;
                clr_cnt    <= '0;
`endif
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end else begin
              case (in_data)
                8'h0A: begin
                  cursor_col <= '0;
                  cursor_row <= adv_row;
                  row_base   <= adv_base;
`ifdef FB_CONSOLE_AUTOCLEAR_EN
                  // No character to write, so the first clear write starts now
                  fb_we      <= 1'b1;
                  fb_addr    <= adv_base;
                  fb_data    <= FILL;
                  clr_cnt    <= CNT_W'(1);
                  state      <= CLR_LINE;
`endif
                end
                8'h0D: cursor_col <= '0;
                8'h08: begin
                  if (cursor_col != 7'd0) begin
                    cursor_col <= cursor_col - 7'd1;
                    fb_we      <= 1'b1;
                    fb_addr    <= row_base + 12'(cursor_col - 7'd1);
                    fb_data    <= 8'h20;
                  end
                end
                8'h0C: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  row_base   <= '0;
                  fb_we      <= 1'b1;
                  fb_addr    <= 12'd0;
                  fb_data    <= FILL;
                  clr_cnt    <= CNT_W'(1);
                  state      <= CLR_ALL;
                end
                default: ;
              endcase
            end
          end
        end

        default: begin
          state   <= CLR_ALL;
          clr_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fb_console_writer.md
# fb_console_writer

Character-stream front end that writes into the VGA controller's text framebuffer over its write-only port (fb_data/fb_addr/fb_we). It sits between the CPU's console output register and the vga_controller. It turns a byte stream into framebuffer writes, keeping a cursor and handling newline, carriage return, backspace and clear-screen. The framebuffer is never read back, so the block wraps to the top row instead of scrolling.

## Interface
- COLS, 80, text columns per row
- ROWS, 30, text rows; COLS*ROWS must be ≤ 4096 (elaboration-time check, fatal on violation)
- FILL, 8'h20, byte written by clear operations
- clk  input  1  core clock; the only clock in the block
- rst  input  1  reset; asynchronous, active-high
- in_data  input  8  character byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a byte this cycle
- fb_data  output  8  framebuffer write data
- fb_addr  output  12  framebuffer write address
- fb_we  output  1  framebuffer write strobe, one write per cycle
- cursor_col  output  7  current cursor column, 0..COLS-1
- cursor_row  output  5  current cursor row, 0..ROWS-1

## Operation
- States: CLR_ALL, IDLE, CLR_LINE.
- Reset values: state=CLR_ALL, clear counter=0, cursor=(0,0), fb_we=0, fb_addr=0, fb_data=0, in_ready=0.
- in_ready = (state==IDLE), decoded from the state register. A byte is accepted on a rising edge where in_valid && in_ready.
- CLR_ALL: writes FILL to addresses 0..COLS*ROWS-1, one per cycle, then goes to IDLE with cursor=(0,0).
- Accepted bytes are decoded as follows:
  - 0x20..0x7E: write the byte at row*COLS+col, then advance col. At col==COLS-1, go to col=0 and row+1.
  - 0x0A: col=0, row+1. No write.
  - 0x0D: col=0. No write.
  - 0x08: if col>0, col-1 and write 0x20 at the new position. If col==0, no effect (no reverse wrap).
  - 0x0C: cursor=(0,0), enter CLR_ALL.
  - Any other byte: consumed and dropped. No write, no cursor change.
- Row increment when row==ROWS-1 wraps to row 0.
- Address arithmetic:
  - fb_addr = row*COLS + col, computed in 12 bits.
  - Implemented as an incrementally maintained row_base register plus col; no multiplier.
  - Never exceeds COLS*ROWS-1.
- CLR_LINE (only with FB_CONSOLE_AUTOCLEAR_EN): writes FILL to row_base..row_base+COLS-1 of the new row, then returns to IDLE.
- Async rst mid-operation aborts any clear and cursor state and restarts CLR_ALL from address 0.

## Timing
- All fb outputs are registered.
- Accepting a printable byte or backspace on edge N drives fb_we=1, with its address and data, during cycle N..N+1. fb_we is 0 in every cycle with no write.
- Throughput in IDLE: one byte per cycle. Back-to-back printables produce consecutive writes.
- CLR_ALL: exactly COLS*ROWS write cycles. in_ready returns high the cycle after the last write (2400 cycles at default after reset or 0x0C).
- CLR_LINE:
  - Entered on the same edge that accepts the row-advancing byte.
  - The character write, if any, occurs in the first cycle.
  - The COLS clear writes follow in the next COLS cycles.
  - in_ready is low for COLS+1 cycles after a printable line wrap, and for COLS cycles after 0x0A.
- cursor_col/cursor_row update on the accepting edge. During clears they hold the post-update cursor.

## Configuration
- FB_CONSOLE_AUTOCLEAR_EN defined:
  - Every row advance (printable wrap or 0x0A) clears the destination row via CLR_LINE, so stale text from the previous pass never shows after a wrap.
- FB_CONSOLE_AUTOCLEAR_EN undefined:
  - CLR_LINE is not compiled in.
  - Row advance only moves the cursor, and in_ready stays high.
  - Old contents remain until overwritten.

## Test plan
- Reset, then wait: fb_we high for exactly 2400 consecutive cycles, addresses 0..2399, data 0x20. After that, in_ready=1 and cursor=(0,0).
- Send 'A','B' back-to-back: writes (0,0x41) then (1,0x42) in consecutive cycles, cursor=(2,0).
- Cursor at col 79, row 29, send 'Z' with AUTOCLEAR on:
  - Write addr 2399 data 0x5A, then 80 writes of 0x20 at addrs 0..79.
  - in_ready low 81 cycles; cursor=(0,0).
  - With AUTOCLEAR off: a single write, in_ready stays high.
- Cursor (5,2), send 0x08: write addr 164 data 0x20, cursor=(4,2). At (0,2), 0x08 gives no write and no cursor change.
- Send 0x0D, then 0x07: cursor col=0, row unchanged. No fb_we for either byte.
- Assert rst during a 0x0C clear at address 1000: fb_we=0 immediately. After release, a full clear from address 0.
